tx_msg_sequencer: RTL and testbench

Parametrised UART transmit sequencer. It drives a byte-wide UART transmitter with a fixed message of MSG_LEN bytes stored in a parameter table. It handshakes each byte on the transmitter's done pulse, inserts an optional inter-byte gap, and supports one-shot or continuous repeat. A per-byte timeout catches a stalled transmitter. It sits between control logic (buttons/top FSM) and the UART TX core.

---
 rtl/uart_pkg.sv | 19 +
 rtl/tx_msg_sequencer_if.sv | 25 ++
 rtl/seq_timer.sv | 28 ++
 rtl/tx_msg_sequencer.sv | 131 +++++++++++++
 tb/tb_tx_msg_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART sequencer definitions: state encoding and default widths.
// Reused by TX- and RX-side sequencers.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    SEND      = ST_SEND,
    WAIT_DONE = ST_WAIT,
    GAP       = ST_GAP
  } state_t;

endpackage

// File: rtl/tx_msg_sequencer_if.sv
// Byte handshake between the message sequencer and a UART TX core.
// Master strobes a byte, slave pulses done when it has shifted out.
interface tx_msg_sequencer_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              tx_dv;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;

  modport master (
    output tx_dv,
    output tx_data,
    input  tx_done
  );

  modport slave (
    input  tx_dv,
    input  tx_data,
    output tx_done
  );

endinterface

// File: rtl/seq_timer.sv
// Clearable up-counter with terminal-count compare.
// Shared by the inter-byte gap and the done timeout.
module seq_timer #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/tx_msg_sequencer.sv
// Feeds a fixed message table to a UART TX core, one byte per done
// pulse, with optional inter-byte gap, repeat and stall timeout.
module tx_msg_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MSG_LEN = 4,
  parameter logic [DATA_W*MSG_LEN-1:0] MSG_INIT =
    {8'h0A, 8'h0D, 8'hAA, 8'h55},
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W = 17,
  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     repeat_en,
  input  logic                     abort,
  tx_msg_sequencer_if.master       tx,
  output logic                     busy,
  output logic [IDX_W-1:0]         byte_idx,
  output logic                     msg_done,
  output logic                     err_timeout
);

  localparam logic [CNT_W-1:0] GAP_TC =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_TC =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(MSG_LEN - 1);

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] idx_n;
  logic             done_n;
  logic             err_n;
  logic             last;
  logic             tc;
  logic             tmr_clr;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_limit;

  function automatic logic [DATA_W-1:0] msg_byte(
    input logic [IDX_W-1:0] i
  );
    return MSG_INIT[int'(i)*DATA_W +: DATA_W];
  endfunction

  assign last = (byte_idx == LAST);

  // Counter restarts on every state change, so each state sees it from 0
  assign tmr_clr   = (state_n != state);
  assign tmr_en    = (state == WAIT_DONE) || (state == GAP);
  assign tmr_limit = (state == GAP) ? GAP_TC : TO_TC;

  seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .tc    (tc)
  );

  always_comb begin
    state_n = state;
    idx_n   = byte_idx;
    done_n  = 1'b0;
    err_n   = err_timeout;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          idx_n   = '0;
          err_n   = 1'b0;
        end
      end
      SEND: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (tx.tx_done) begin
          done_n = last;
          if (abort || (last && !repeat_en)) begin
            state_n = IDLE;
          end else begin
            if (GAP_CYCLES > 0) state_n = GAP;
            else                state_n = SEND;
            idx_n = last ? '0 : byte_idx + 1'b1;
          end
        end else if (tc) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      GAP: begin
        if (abort)   state_n = IDLE;
        else if (tc) state_n = SEND;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) idx_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx.tx_dv    <= 1'b0;
      tx.tx_data  <= '0;
      busy        <= 1'b0;
      byte_idx    <= '0;
      msg_done    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      byte_idx    <= idx_n;
      msg_done    <= done_n;
      err_timeout <= err_n;
      busy        <= (state_n != IDLE);
      tx.tx_dv    <= (state_n == SEND);
      if (state_n == SEND) begin
        tx.tx_data <= msg_byte(idx_n);
      end else if (state_n == IDLE) begin
        tx.tx_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tx_msg_sequencer.sv
// Directed bench: three sequencer instances (back-to-back, gapped,
// single-byte), each driven by a small transmitter model.
module tb_tx_msg_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic start_c = 1'b0;
  logic repeat_en = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  tx_msg_sequencer_if #(.DATA_W(8)) ifa ();
  tx_msg_sequencer_if #(.DATA_W(8)) ifb ();
  tx_msg_sequencer_if #(.DATA_W(8)) ifc ();

  logic       busy_a, md_a, err_a;
  logic [1:0] idx_a;
  logic       busy_b, md_b, err_b;
  logic [1:0] idx_b;
  logic       busy_c, md_c, err_c;
  logic [0:0] idx_c;

  tx_msg_sequencer #(
    .GAP_CYCLES     (0),
    .TIMEOUT_CYCLES (20)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start_a),
    .repeat_en   (repeat_en),
    .abort       (abort),
    .tx          (ifa.master),
    .busy        (busy_a),
    .byte_idx    (idx_a),
    .msg_done    (md_a),
    .err_timeout (err_a)
  );

  tx_msg_sequencer #(
    .GAP_CYCLES (5)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .repeat_en   (repeat_en),
    .abort       (abort),
    .tx          (ifb.master),
    .busy        (busy_b),
    .byte_idx    (idx_b),
    .msg_done    (md_b),
    .err_timeout (err_b)
  );

  tx_msg_sequencer #(
    .MSG_LEN  (1),
    .MSG_INIT (8'h3C)
  ) dut_c (
    .clk         (clk),
    .rst         (rst),
    .start       (start_c),
    .repeat_en   (repeat_en),
    .abort       (abort),
    .tx          (ifc.master),
    .busy        (busy_c),
    .byte_idx    (idx_c),
    .msg_done    (md_c),
    .err_timeout (err_c)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] by_a[$], by_b[$], by_c[$];
  int ix_a[$], ix_b[$], ix_c[$];
  int dv_a[$], dv_b[$], dv_c[$];
  int td_a[$], td_b[$], td_c[$];
  int md_n_a, md_n_b, md_n_c;
  int cd_a, cd_b, cd_c;
  logic stall_a = 1'b0;
  logic spur_a = 1'b0;

  // transmitter models: done 10 negedges after a strobe, logged when driven
  always @(negedge clk) begin
    if (ifa.tx_dv) begin
      by_a.push_back(ifa.tx_data);
      ix_a.push_back(int'(idx_a));
      dv_a.push_back(cyc);
    end
    if (md_a) md_n_a++;
    if (rst) cd_a = 0;
    else if (ifa.tx_dv && !stall_a) cd_a = 10;
    else if (cd_a > 0) cd_a--;
    ifa.tx_done = (cd_a == 1) || spur_a;
    if (ifa.tx_done) td_a.push_back(cyc);
  end

  always @(negedge clk) begin
    if (ifb.tx_dv) begin
      by_b.push_back(ifb.tx_data);
      ix_b.push_back(int'(idx_b));
      dv_b.push_back(cyc);
    end
    if (md_b) md_n_b++;
    if (rst) cd_b = 0;
    else if (ifb.tx_dv) cd_b = 10;
    else if (cd_b > 0) cd_b--;
    ifb.tx_done = (cd_b == 1);
    if (ifb.tx_done) td_b.push_back(cyc);
  end

  always @(negedge clk) begin
    if (ifc.tx_dv) begin
      by_c.push_back(ifc.tx_data);
      ix_c.push_back(int'(idx_c));
      dv_c.push_back(cyc);
    end
    if (md_c) md_n_c++;
    if (rst) cd_c = 0;
    else if (ifc.tx_dv) cd_c = 10;
    else if (cd_c > 0) cd_c--;
    ifc.tx_done = (cd_c == 1);
    if (ifc.tx_done) td_c.push_back(cyc);
  end

  int nvec = 0;
  int nerr = 0;
  int rep_target = 1;
  int abort_at = -1;
  logic [7:0] msg[4] = '{8'h55, 8'hAA, 8'h0D, 8'h0A};

  typedef struct {
    int rep;
    int abort_at;
    int n_bytes;
    int n_done;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit busy_of(input int w);
    case (w)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic int md_of(input int w);
    case (w)
      0: return md_n_a;
      1: return md_n_b;
      default: return md_n_c;
    endcase
  endfunction

  function automatic int nby_of(input int w);
    case (w)
      0: return by_a.size();
      1: return by_b.size();
      default: return by_c.size();
    endcase
  endfunction

  function automatic bit dv_of(input int w);
    case (w)
      0: return ifa.tx_dv;
      1: return ifb.tx_dv;
      default: return ifc.tx_dv;
    endcase
  endfunction

  task automatic clr_logs();
    by_a.delete(); ix_a.delete(); dv_a.delete(); td_a.delete();
    by_b.delete(); ix_b.delete(); dv_b.delete(); td_b.delete();
    by_c.delete(); ix_c.delete(); dv_c.delete(); td_c.delete();
    md_n_a = 0;
    md_n_b = 0;
    md_n_c = 0;
  endtask

  task automatic kick(input int w);
    repeat_en = (rep_target > 1);
    @(negedge clk);
    if (w == 0) start_a = 1'b1;
    else if (w == 1) start_b = 1'b1;
    else start_c = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_idle(input int w, output int ic);
    ic = -1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      repeat_en = (md_of(w) < rep_target - 1);
      if (abort_at >= 0 && nby_of(w) == abort_at + 1 && !dv_of(w))
        abort = 1'b1;
      if (!busy_of(w)) begin
        ic = cyc;
        break;
      end
    end
    if (ic < 0) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int ic;
    int ec;
    int ab;
    bit seen;

    vt[0] = '{1, -1, 4, 1};
    vt[1] = '{2, -1, 8, 2};
    vt[2] = '{3, -1, 12, 3};
    vt[3] = '{1, 1, 2, 0};
    vt[4] = '{1, 0, 1, 0};
    vt[5] = '{1, 3, 4, 1};
    vt[6] = '{2, 3, 4, 1};

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_dv_a", ifa.tx_dv, 0);
    chk("rst_data_a", ifa.tx_data, 0);
    chk("rst_idx_a", idx_a, 0);
    chk("rst_md_a", md_a, 0);
    chk("rst_err_a", err_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_busy_c", busy_c, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven message runs on the back-to-back instance
    for (int v = 0; v < 7; v++) begin
      clr_logs();
      rep_target = vt[v].rep;
      abort_at = vt[v].abort_at;
      kick(0);
      wait_idle(0, ic);
      repeat (3) @(negedge clk);
      abort = 1'b0;
      abort_at = -1;
      repeat_en = 1'b0;
      chk($sformatf("v%0d_nbytes", v), by_a.size(), vt[v].n_bytes);
      chk($sformatf("v%0d_ndone", v), md_n_a, vt[v].n_done);
      chk($sformatf("v%0d_ntxdone", v), td_a.size(), vt[v].n_bytes);
      for (int i = 0; i < by_a.size(); i++) begin
        chk($sformatf("v%0d_byte%0d", v, i), by_a[i], msg[i % 4]);
        chk($sformatf("v%0d_idx%0d", v, i), ix_a[i], i % 4);
      end
      for (int i = 0; i + 1 < by_a.size() && i < td_a.size(); i++)
        chk($sformatf("v%0d_b2b%0d", v, i), dv_a[i+1] - td_a[i], 1);
      chk($sformatf("v%0d_idle_busy", v), busy_a, 0);
      chk($sformatf("v%0d_idle_data", v), ifa.tx_data, 0);
      chk($sformatf("v%0d_idle_err", v), err_a, 0);
    end
    rep_target = 1;

    // gapped instance: 5 idle cycles between done and next strobe
    clr_logs();
    kick(1);
    wait_idle(1, ic);
    repeat (3) @(negedge clk);
    chk("gap_nbytes", by_b.size(), 4);
    chk("gap_ndone", md_n_b, 1);
    for (int i = 0; i < by_b.size(); i++)
      chk($sformatf("gap_byte%0d", i), by_b[i], msg[i % 4]);
    for (int i = 0; i < 3 && i + 1 < by_b.size() && i < td_b.size(); i++)
      chk($sformatf("gap_space%0d", i), dv_b[i+1] - td_b[i], 6);
    if (td_b.size() == 4) chk("gap_final_idle", ic - td_b[3], 1);
    else chk("gap_final_ntxdone", td_b.size(), 4);

    // abort while in the gap drops to idle on the next edge
    clr_logs();
    kick(1);
    seen = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (td_b.size() >= 1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("gapabort_wait", 0, 1);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    ab = cyc;
    wait_idle(1, ic);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("gapabort_latency", ic - ab, 1);
    chk("gapabort_nbytes", by_b.size(), 1);
    chk("gapabort_ndone", md_n_b, 0);

    // stalled transmitter: 20 WAIT_DONE cycles then sticky error
    clr_logs();
    stall_a = 1'b1;
    repeat (2) @(negedge clk);
    kick(0);
    ec = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (err_a) begin
        ec = cyc;
        break;
      end
    end
    if (ec < 0 || dv_a.size() == 0) begin
      chk("timeout_seen", 0, 1);
    end else begin
      chk("timeout_latency", ec - dv_a[0], 21);
      chk("timeout_busy", busy_a, 0);
    end
    repeat (5) @(negedge clk);
    chk("timeout_sticky", err_a, 1);
    chk("timeout_nbytes", by_a.size(), 1);
    chk("timeout_ndone", md_n_a, 0);
    stall_a = 1'b0;

    clr_logs();
    @(negedge clk);
    start_a = 1'b1;
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (ifa.tx_dv) begin
        seen = 1;
        break;
      end
    end
    start_a = 1'b0;
    if (!seen) chk("restart_dv", 0, 1);
    chk("restart_err_clr", err_a, 0);
    chk("restart_data", ifa.tx_data, 8'h55);
    chk("restart_idx", idx_a, 0);
    wait_idle(0, ic);
    repeat (3) @(negedge clk);
    chk("restart_nbytes", by_a.size(), 4);
    chk("restart_ndone", md_n_a, 1);

    // start held high: ignored while busy, restarts once idle
    clr_logs();
    @(negedge clk);
    start_a = 1'b1;
    seen = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (by_a.size() >= 5) begin
        seen = 1;
        break;
      end
    end
    start_a = 1'b0;
    if (!seen) chk("held_wait", 0, 1);
    wait_idle(0, ic);
    repeat (3) @(negedge clk);
    chk("held_nbytes", by_a.size(), 8);
    chk("held_ndone", md_n_a, 2);
    if (by_a.size() >= 5 && td_a.size() >= 4)
      chk("held_restart_lat", dv_a[4] - td_a[3], 2);
    for (int i = 0; i < by_a.size(); i++)
      chk($sformatf("held_byte%0d", i), by_a[i], msg[i % 4]);

    // async reset in WAIT_DONE of byte 2
    clr_logs();
    kick(0);
    seen = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (by_a.size() == 3 && !ifa.tx_dv) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("rst_mid_wait", 0, 1);
    chk("pre_rst_idx", idx_a, 2);
    chk("pre_rst_data", ifa.tx_data, 8'h0D);
    #1 rst = 1'b1;
    #1;
    chk("async_busy", busy_a, 0);
    chk("async_dv", ifa.tx_dv, 0);
    chk("async_data", ifa.tx_data, 0);
    chk("async_idx", idx_a, 0);
    chk("async_md", md_a, 0);
    chk("async_err", err_a, 0);
    @(negedge clk);
    rst = 1'b0;
    clr_logs();
    @(negedge clk);
    #1 spur_a = 1'b1;
    @(negedge clk);
    #1 spur_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("spur_txdone_seen", td_a.size(), 1);
    chk("spur_nbytes", by_a.size(), 0);
    chk("spur_busy", busy_a, 0);
    kick(0);
    wait_idle(0, ic);
    repeat (3) @(negedge clk);
    chk("post_rst_nbytes", by_a.size(), 4);
    if (by_a.size() > 0) begin
      chk("post_rst_byte0", by_a[0], 8'h55);
      chk("post_rst_idx0", ix_a[0], 0);
    end

    // single-byte message repeated three times
    clr_logs();
    rep_target = 3;
    kick(2);
    wait_idle(2, ic);
    repeat (3) @(negedge clk);
    rep_target = 1;
    repeat_en = 1'b0;
    chk("len1_nbytes", by_c.size(), 3);
    chk("len1_ndone", md_n_c, 3);
    for (int i = 0; i < by_c.size(); i++) begin
      chk($sformatf("len1_byte%0d", i), by_c[i], 8'h3C);
      chk($sformatf("len1_idx%0d", i), ix_c[i], 0);
    end
    for (int i = 0; i + 1 < by_c.size() && i < td_c.size(); i++)
      chk($sformatf("len1_b2b%0d", i), dv_c[i+1] - td_c[i], 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
